// File: rtl/regbank_debug_arbiter_pkg.sv
// Shared decode-stage definitions: arbiter FSM encoding, default widths and
// the helper that tells who owns the register bank read ports.
package regbank_debug_arbiter_pkg;

    localparam int NB_DATA_DEF     = 32;
    localparam int NB_REGISTER_DEF = 5;
    localparam int N_REGISTERS_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HALT = 3'd1,
        ST_READ      = 3'd2,
        ST_SEND      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // The pipeline keeps the read ports until it has actually acknowledged the freeze.
    function automatic logic pipe_owns_bank(input state_t st);
        return (st == ST_IDLE) || (st == ST_WAIT_HALT);
    endfunction

endpackage

// File: rtl/regbank_debug_arbiter_if.sv
// Bundle of the pipeline, register bank and debug-sink signals around the arbiter.
interface regbank_debug_arbiter_if
    import regbank_debug_arbiter_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_REGISTER = NB_REGISTER_DEF
);
    logic                   i_dump_start;
    logic                   i_dump_abort;
    logic                   i_pipeline_halted;
    logic [NB_REGISTER-1:0] i_pipe_rs;
    logic [NB_REGISTER-1:0] i_pipe_rt;
    logic [NB_DATA-1:0]     i_bank_data_0;
    logic                   i_data_ready;
    logic [NB_REGISTER-1:0] o_read_reg_sel_0;
    logic [NB_REGISTER-1:0] o_read_reg_sel_1;
    logic                   o_stall_req;
    logic [NB_DATA-1:0]     o_data;
    logic                   o_data_valid;
    logic [NB_REGISTER-1:0] o_reg_index;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_error;

    modport slave (
        input  i_dump_start, i_dump_abort, i_pipeline_halted, i_pipe_rs, i_pipe_rt,
               i_bank_data_0, i_data_ready,
        output o_read_reg_sel_0, o_read_reg_sel_1, o_stall_req, o_data, o_data_valid,
               o_reg_index, o_busy, o_done, o_error
    );

    modport master (
        output i_dump_start, i_dump_abort, i_pipeline_halted, i_pipe_rs, i_pipe_rt,
               i_bank_data_0, i_data_ready,
        input  o_read_reg_sel_0, o_read_reg_sel_1, o_stall_req, o_data, o_data_valid,
               o_reg_index, o_busy, o_done, o_error
    );

endinterface

// File: rtl/regbank_port_mux.sv
// Register bank read-select mux: pipeline selects or the dump index on port 0.
module regbank_port_mux
    import regbank_debug_arbiter_pkg::*;
#(
    parameter int NB_REGISTER = NB_REGISTER_DEF
) (
    input  logic                   select_pipe,
    input  logic [NB_REGISTER-1:0] pipe_rs,
    input  logic [NB_REGISTER-1:0] pipe_rt,
    input  logic [NB_REGISTER-1:0] dump_index,
    output logic [NB_REGISTER-1:0] read_reg_sel_0,
    output logic [NB_REGISTER-1:0] read_reg_sel_1
);

    // Port 1 is parked on register 0 while the dump owns the bank.
    always_comb begin
        read_reg_sel_0 = pipe_rs;
        read_reg_sel_1 = pipe_rt;
        if (select_pipe) begin
            read_reg_sel_0 = pipe_rs;
            read_reg_sel_1 = pipe_rt;
        end else begin
            read_reg_sel_0 = dump_index;
            read_reg_sel_1 = {NB_REGISTER{1'b0}};
        end
    end

endmodule

// File: rtl/regbank_debug_arbiter.sv
// Debug dump arbiter: freezes the pipeline, walks the register bank and streams
// every value over a valid/ready handshake before handing the ports back.
module regbank_debug_arbiter
    import regbank_debug_arbiter_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_REGISTER = NB_REGISTER_DEF,
    parameter int N_REGISTERS = N_REGISTERS_DEF
) (
    input logic                    i_clock,
    input logic                    i_reset,
    regbank_debug_arbiter_if.slave bus
);

    localparam logic [NB_REGISTER-1:0] LAST_INDEX = NB_REGISTER'(N_REGISTERS - 1);

    state_t                 state_r, state_s;
    logic [NB_REGISTER-1:0] index_r, index_s;
    logic [NB_DATA-1:0]     data_r, data_s;
    logic [NB_REGISTER-1:0] reg_index_r, reg_index_s;
    logic                   valid_r, valid_s;
    logic                   stall_r, stall_s;
    logic                   done_r, done_s;
    logic                   error_r, error_s;

    // State and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            index_r     <= {NB_REGISTER{1'b0}};
            data_r      <= {NB_DATA{1'b0}};
            reg_index_r <= {NB_REGISTER{1'b0}};
            valid_r     <= 1'b0;
            stall_r     <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            index_r     <= index_s;
            data_r      <= data_s;
            reg_index_r <= reg_index_s;
            valid_r     <= valid_s;
            stall_r     <= stall_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    // Next-state and next-output decode; abort outranks a dropped halt.
    always_comb begin
        state_s     = state_r;
        index_s     = index_r;
        data_s      = data_r;
        reg_index_s = reg_index_r;
        valid_s     = valid_r;
        stall_s     = stall_r;
        done_s      = 1'b0;
        error_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                valid_s = 1'b0;
                stall_s = 1'b0;
                if (bus.i_dump_abort) begin
                    state_s = ST_IDLE;
                end else if (bus.i_dump_start) begin
                    state_s = ST_WAIT_HALT;
                    stall_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_HALT: begin
                if (bus.i_dump_abort) begin
                    state_s = ST_IDLE;
                    stall_s = 1'b0;
                end else if (bus.i_pipeline_halted) begin
                    state_s = ST_READ;
                    index_s = {NB_REGISTER{1'b0}};
                end else begin
                    state_s = ST_WAIT_HALT;
                end
            end
            ST_READ: begin
                if (bus.i_dump_abort || !bus.i_pipeline_halted) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    stall_s = 1'b0;
                    error_s = !bus.i_dump_abort;
                end else begin
                    state_s     = ST_SEND;
                    data_s      = bus.i_bank_data_0;
                    reg_index_s = index_r;
                    valid_s     = 1'b1;
                end
            end
            ST_SEND: begin
                if (bus.i_dump_abort || !bus.i_pipeline_halted) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    stall_s = 1'b0;
                    error_s = !bus.i_dump_abort;
                end else if (bus.i_data_ready) begin
                    valid_s = 1'b0;
                    if (index_r == LAST_INDEX) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        stall_s = 1'b0;
                    end else begin
                        state_s = ST_READ;
                        index_s = index_r + {{(NB_REGISTER-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                stall_s = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                stall_s = 1'b0;
            end
        endcase
    end

    regbank_port_mux #(
        .NB_REGISTER (NB_REGISTER)
    ) u_port_mux (
        .select_pipe    (pipe_owns_bank(state_r)),
        .pipe_rs        (bus.i_pipe_rs),
        .pipe_rt        (bus.i_pipe_rt),
        .dump_index     (index_r),
        .read_reg_sel_0 (bus.o_read_reg_sel_0),
        .read_reg_sel_1 (bus.o_read_reg_sel_1)
    );

    assign bus.o_stall_req  = stall_r;
    assign bus.o_data       = data_r;
    assign bus.o_data_valid = valid_r;
    assign bus.o_reg_index  = reg_index_r;
    assign bus.o_busy       = (state_r != ST_IDLE);
    assign bus.o_done       = done_r;
    assign bus.o_error      = error_r;

endmodule

// File: tb/tb_regbank_debug_arbiter.sv
// Self-checking bench for regbank_debug_arbiter: idle vector table, scoreboarded
// dumps and hand-written abort / halt-drop / reset sequences.
module tb_regbank_debug_arbiter;
    import regbank_debug_arbiter_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 32;

    typedef struct packed {
        logic [NB_REG-1:0]  idx;
        logic [NB_DATA-1:0] data;
    } beat_t;

    typedef struct {
        logic              start;
        logic              abort;
        logic [NB_REG-1:0] rs;
        logic [NB_REG-1:0] rt;
        logic              busy;
        logic              stall;
        logic [NB_REG-1:0] sel0;
        logic [NB_REG-1:0] sel1;
    } vec_t;

    logic i_clock = 1'b0;
    logic i_reset;
    always #5 i_clock = ~i_clock;

    regbank_debug_arbiter_if #(.NB_DATA(NB_DATA), .NB_REGISTER(NB_REG)) bus ();

    regbank_debug_arbiter #(
        .NB_DATA     (NB_DATA),
        .NB_REGISTER (NB_REG),
        .N_REGISTERS (N_REGS)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    logic [NB_DATA-1:0] bank [N_REGS];
    assign bus.i_bank_data_0 = bank[bus.o_read_reg_sel_0];

    beat_t sb_q[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    beats = 0;
    int    done_cnt = 0;
    int    err_cnt = 0;
    vec_t  vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_dump_start      = 1'b0;
        bus.i_dump_abort      = 1'b0;
        bus.i_pipeline_halted = 1'b0;
        bus.i_data_ready      = 1'b0;
        bus.i_pipe_rs         = 5'd0;
        bus.i_pipe_rt         = 5'd0;
    endtask

    task automatic push_all();
        beat_t b;
        for (int k = 0; k < N_REGS; k++) begin
            b.idx  = NB_REG'(k);
            b.data = NB_DATA'(k * 4 + 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic start_dump();
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start      = 1'b0;
        bus.i_pipeline_halted = 1'b1;
    endtask

    task automatic wait_done(input int budget, input logic toggle, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (toggle) bus.i_data_ready = ~bus.i_data_ready;
            tick();
            cycles++;
            if (bus.o_done) seen = 1'b1;
        end
        if (!seen) chk("timeout_done", 32'd0, 32'd1);
    endtask

    // Waits for SEND (want_valid=1) or READ (want_valid=0) of the given index.
    task automatic wait_index(input logic want_valid, input logic [NB_REG-1:0] idx, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (want_valid)
                seen = bus.o_data_valid && (bus.o_reg_index == idx);
            else
                seen = bus.o_busy && bus.o_stall_req && !bus.o_data_valid && (bus.o_read_reg_sel_0 == idx);
        end
        if (!seen) chk("timeout_index", 32'd0, 32'd1);
    endtask

    // Output monitor: scoreboard pops on handshake and hold-stability checks.
    initial begin : monitor
        logic              hold_pend;
        logic [NB_DATA-1:0] hold_data;
        logic [NB_REG-1:0]  hold_idx;
        beat_t             b;
        hold_pend = 1'b0;
        hold_data = '0;
        hold_idx  = '0;
        forever begin
            @(negedge i_clock);
            if (i_reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 32'(bus.o_data_valid), 32'd1);
                    chk("hold_data", bus.o_data, hold_data);
                    chk("hold_idx", 32'(bus.o_reg_index), 32'(hold_idx));
                end
                if (bus.o_done) done_cnt++;
                if (bus.o_error) err_cnt++;
                if (bus.o_data_valid && bus.i_data_ready) begin
                    beats++;
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        b = sb_q.pop_front();
                        chk("beat_idx", 32'(bus.o_reg_index), 32'(b.idx));
                        chk("beat_data", bus.o_data, b.data);
                    end
                end
                hold_pend = bus.o_data_valid && !bus.i_data_ready && !bus.i_dump_abort
                            && bus.i_pipeline_halted;
                hold_data = bus.o_data;
                hold_idx  = bus.o_reg_index;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cycles;
        for (int k = 0; k < N_REGS; k++) bank[k] = NB_DATA'(k * 4 + 1);
        vt[0] = '{1'b0, 1'b0, 5'd3,  5'd7,  1'b0, 1'b0, 5'd3,  5'd7};
        vt[1] = '{1'b1, 1'b1, 5'd1,  5'd2,  1'b0, 1'b0, 5'd1,  5'd2};
        vt[2] = '{1'b1, 1'b0, 5'd9,  5'd10, 1'b1, 1'b1, 5'd9,  5'd10};
        vt[3] = '{1'b1, 1'b0, 5'd4,  5'd5,  1'b1, 1'b1, 5'd4,  5'd5};
        vt[4] = '{1'b0, 1'b1, 5'd31, 5'd0,  1'b0, 1'b0, 5'd31, 5'd0};
        vt[5] = '{1'b0, 1'b0, 5'd17, 5'd18, 1'b0, 1'b0, 5'd17, 5'd18};

        // Reset values
        idle_inputs();
        i_reset = 1'b1;
        bus.i_pipe_rs = 5'd3;
        #12;
        chk("rst_valid", 32'(bus.o_data_valid), 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        chk("rst_stall", 32'(bus.o_stall_req), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_error", 32'(bus.o_error), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_sel0", 32'(bus.o_read_reg_sel_0), 32'd3);
        @(negedge i_clock);
        i_reset = 1'b0;
        tick();

        // Idle / start / abort vector table
        for (int v = 0; v < 6; v++) begin
            bus.i_dump_start = vt[v].start;
            bus.i_dump_abort = vt[v].abort;
            bus.i_pipe_rs    = vt[v].rs;
            bus.i_pipe_rt    = vt[v].rt;
            tick();
            bus.i_dump_start = 1'b0;
            bus.i_dump_abort = 1'b0;
            chk($sformatf("vt%0d_busy", v), 32'(bus.o_busy), 32'(vt[v].busy));
            chk($sformatf("vt%0d_stall", v), 32'(bus.o_stall_req), 32'(vt[v].stall));
            chk($sformatf("vt%0d_sel0", v), 32'(bus.o_read_reg_sel_0), 32'(vt[v].sel0));
            chk($sformatf("vt%0d_sel1", v), 32'(bus.o_read_reg_sel_1), 32'(vt[v].sel1));
            chk($sformatf("vt%0d_valid", v), 32'(bus.o_data_valid), 32'd0);
        end

        // Full dump, ready high: 65 cycles from halt to DONE
        idle_inputs();
        push_all();
        beats = 0; done_cnt = 0;
        bus.i_data_ready = 1'b1;
        start_dump();
        wait_done(200, 1'b0, cycles);
        chk("full_cycles", 32'(cycles), 32'd65);
        chk("full_done_stall", 32'(bus.o_stall_req), 32'd0);
        chk("full_beats", 32'(beats), 32'd32);
        chk("full_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();
        chk("full_done_pulse", 32'(bus.o_done), 32'd0);
        chk("full_idle", 32'(bus.o_busy), 32'd0);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);

        // Full dump with ready toggling every cycle
        idle_inputs();
        push_all();
        beats = 0; done_cnt = 0;
        bus.i_data_ready = 1'b0;
        start_dump();
        wait_done(400, 1'b1, cycles);
        chk("tog_beats", 32'(beats), 32'd32);
        chk("tog_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();
        chk("tog_done_cnt", 32'(done_cnt), 32'd1);

        // Halt withheld for 20 cycles
        idle_inputs();
        push_all();
        beats = 0; done_cnt = 0;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wait_stall", 32'(bus.o_stall_req), 32'd1);
            chk("wait_busy", 32'(bus.o_busy), 32'd1);
            chk("wait_valid", 32'(bus.o_data_valid), 32'd0);
        end
        chk("wait_no_beats", 32'(beats), 32'd0);
        bus.i_pipeline_halted = 1'b1;
        bus.i_data_ready      = 1'b1;
        wait_done(200, 1'b0, cycles);
        chk("wait_beats", 32'(beats), 32'd32);

        // Abort during SEND at index 10
        tick();
        idle_inputs();
        push_all();
        beats = 0; done_cnt = 0;
        bus.i_data_ready = 1'b1;
        start_dump();
        wait_index(1'b1, 5'd10, 100);
        bus.i_data_ready = 1'b0;
        bus.i_dump_abort = 1'b1;
        bus.i_pipe_rs    = 5'd12;
        bus.i_pipe_rt    = 5'd21;
        tick();
        bus.i_dump_abort = 1'b0;
        chk("abort_valid", 32'(bus.o_data_valid), 32'd0);
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        chk("abort_stall", 32'(bus.o_stall_req), 32'd0);
        chk("abort_sel0", 32'(bus.o_read_reg_sel_0), 32'd12);
        chk("abort_sel1", 32'(bus.o_read_reg_sel_1), 32'd21);
        chk("abort_sb_left", 32'(sb_q.size()), 32'd22);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_error", 32'(err_cnt), 32'd0);
        sb_q.delete();

        // Halt dropped in READ at index 4; extra start during dump ignored
        idle_inputs();
        push_all();
        beats = 0; err_cnt = 0;
        bus.i_pipe_rs    = 5'd3;
        bus.i_data_ready = 1'b1;
        start_dump();
        wait_index(1'b0, 5'd2, 100);
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        wait_index(1'b0, 5'd4, 100);
        bus.i_pipeline_halted = 1'b0;
        tick();
        chk("herr_error", 32'(bus.o_error), 32'd1);
        chk("herr_busy", 32'(bus.o_busy), 32'd0);
        chk("herr_valid", 32'(bus.o_data_valid), 32'd0);
        chk("herr_stall", 32'(bus.o_stall_req), 32'd0);
        tick();
        chk("herr_pulse", 32'(bus.o_error), 32'd0);
        chk("herr_idle", 32'(bus.o_busy), 32'd0);
        chk("herr_err_cnt", 32'(err_cnt), 32'd1);
        chk("herr_sb_left", 32'(sb_q.size()), 32'd28);
        sb_q.delete();

        // Asynchronous reset mid-SEND at index 7
        idle_inputs();
        push_all();
        bus.i_data_ready = 1'b1;
        start_dump();
        wait_index(1'b1, 5'd7, 100);
        bus.i_data_ready = 1'b0;
        bus.i_pipe_rs    = 5'd3;
        #2;
        i_reset = 1'b1;
        #1;
        chk("mrst_valid", 32'(bus.o_data_valid), 32'd0);
        chk("mrst_data", bus.o_data, 32'd0);
        chk("mrst_index", 32'(bus.o_reg_index), 32'd0);
        chk("mrst_stall", 32'(bus.o_stall_req), 32'd0);
        chk("mrst_busy", 32'(bus.o_busy), 32'd0);
        chk("mrst_done", 32'(bus.o_done), 32'd0);
        chk("mrst_error", 32'(bus.o_error), 32'd0);
        chk("mrst_sel0", 32'(bus.o_read_reg_sel_0), 32'd3);
        @(negedge i_clock);
        i_reset = 1'b0;
        idle_inputs();
        sb_q.delete();
        tick();
        chk("mrst_stay_idle", 32'(bus.o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
